// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage between execute and writeback.
// ALU-only instructions retire one cycle after acceptance. Loads and stores
// latch their operands, hold a single data-memory request until dmem_ack or
// an ack timeout, then retire with a one-cycle writeback pulse.
//
// Optional build macro: MEM_ALIGN_CHECK_EN. When defined, a memory op whose
// address is not word aligned is rejected without touching memory and
// retires with align_err. When undefined, any address is passed through and
// align_err stays low.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   ex_valid           execute stage offers an instruction
//   ALU_result         ALU output / memory address
//   Reg2_out           store data
//   R_dest_exec        destination register
//   mem_rd/mem_wr      load / store (both high = store)
//   reg_wr             instruction writes a register
//   stall_out          upstream must hold while high (memory access in flight)
//   dmem_req/dmem_we   memory request / write enable
//   dmem_addr/dmem_wdata  memory address / write data
//   dmem_rdata/dmem_ack   read data / access-complete strobe
//   wb_valid           one-cycle retire pulse
//   wb_data/wb_dest/wb_regwr  writeback payload
//   bus_err/align_err  one-cycle error pulses
module mem_access_stage #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Reg2_out,
  input  logic [4:0]  R_dest_exec,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        reg_wr,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic        wb_regwr,
  output logic        bus_err,
  output logic        align_err
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((ACK_TIMEOUT == 0) ? 32'd0 : ACK_TIMEOUT - 32'd1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [4:0]       dest_q, dest_d;
  logic             we_q, we_d;
  logic             regwr_q, regwr_d;
  logic             wb_valid_q, wb_valid_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [4:0]       wb_dest_q, wb_dest_d;
  logic             wb_regwr_q, wb_regwr_d;
  logic             bus_err_q, bus_err_d;
  logic             align_err_q, align_err_d;

  logic             misaligned;
  logic             timeout_hit;
  logic             in_access;

  // Alignment screen for incoming memory ops (compiled out by default)
`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |ALU_result[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // Last permitted ACCESS cycle without ack; a zero limit never expires
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign in_access   = (state_q == ACCESS);

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dest_d      = dest_q;
    we_d        = we_q;
    regwr_d     = regwr_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_dest_d   = wb_dest_q;
    wb_regwr_d  = wb_regwr_q;
    bus_err_d   = 1'b0;
    align_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!(mem_rd || mem_wr)) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ALU_result;
            wb_dest_d  = R_dest_exec;
            wb_regwr_d = reg_wr;
          end else if (misaligned) begin
            wb_valid_d  = 1'b1;
            wb_data_d   = ALU_result;
            wb_dest_d   = R_dest_exec;
            wb_regwr_d  = 1'b0;
            align_err_d = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = '0;
            addr_d  = ALU_result;
            wdata_d = Reg2_out;
            dest_d  = R_dest_exec;
            we_d    = mem_wr;   // rd+wr together behaves as a store
            regwr_d = reg_wr;
          end
        end
      end
      ACCESS: begin
        // Ack takes priority over an expiring timeout in the same cycle
        if (dmem_ack) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_data_d  = we_q ? addr_q : dmem_rdata;
          wb_dest_d  = dest_q;
          wb_regwr_d = regwr_q & ~we_q;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_data_d  = addr_q;
          wb_dest_d  = dest_q;
          wb_regwr_d = 1'b0;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and payload registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      dest_q      <= '0;
      we_q        <= 1'b0;
      regwr_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_dest_q   <= '0;
      wb_regwr_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      dest_q      <= dest_d;
      we_q        <= we_d;
      regwr_q     <= regwr_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_dest_q   <= wb_dest_d;
      wb_regwr_q  <= wb_regwr_d;
      bus_err_q   <= bus_err_d;
      align_err_q <= align_err_d;
    end
  end

  // Memory-side outputs decode straight from registers so reset clears them at once
  assign stall_out  = in_access;
  assign dmem_req   = in_access;
  assign dmem_we    = in_access & we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_dest    = wb_dest_q;
  assign wb_regwr   = wb_regwr_q;
  assign bus_err    = bus_err_q;
  assign align_err  = align_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a driver issues instructions and
// plays the memory side, pushing the architecturally expected retire record;
// a monitor pops and compares on every writeback pulse.
module tb_mem_access_stage;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ALU_result;
  logic [31:0] Reg2_out;
  logic [4:0]  R_dest_exec;
  logic        mem_rd, mem_wr, reg_wr;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_regwr, bus_err, align_err;

  mem_access_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ALU_result(ALU_result),
    .Reg2_out(Reg2_out), .R_dest_exec(R_dest_exec), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .reg_wr(reg_wr), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest),
    .wb_regwr(wb_regwr), .bus_err(bus_err), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        regwr;
    logic        be;
    logic        ae;
    logic        chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every retire pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb_valid", 32'(wb_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wb_regwr", 32'(wb_regwr), 32'(e.regwr));
          check("bus_err", 32'(bus_err), 32'(e.be));
          check("align_err", 32'(align_err), 32'(e.ae));
          if (e.chk_data) begin
            check("wb_data", wb_data, e.data);
            check("wb_dest", 32'(wb_dest), 32'(e.dest));
          end
        end
      end else begin
        check("err_without_wb", 32'({bus_err, align_err}), 32'd0);
      end
    end
  end

  function automatic logic addr_misaligned(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return |a[1:0];
`else
    return (a[1:0] != a[1:0]);
`endif
  endfunction

  // Issue one instruction from posedge+1 in IDLE; returns at posedge+1 in IDLE.
  // ack_lat: ACCESS cycle on which ack is given (0 = never).
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] dest,
                       input logic rw, input int ack_lat, input logic [31:0] rdata);
    exp_t e;
    logic memop, store, acked;
    int   cycles;
    memop = rd | wr;
    store = wr;
    acked = (ack_lat != 0) && (ack_lat <= int'(TO));
    cycles = acked ? ack_lat : int'(TO);
    e.dest = dest; e.be = 1'b0; e.ae = 1'b0; e.chk_data = 1'b1; e.data = addr; e.regwr = rw;
    if (memop && addr_misaligned(addr)) begin
      e.regwr = 1'b0; e.ae = 1'b1; e.chk_data = 1'b0;
    end else if (memop && acked) begin
      e.data  = store ? addr : rdata;
      e.regwr = rw & ~store;
    end else if (memop) begin
      e.regwr = 1'b0; e.be = 1'b1; e.chk_data = 1'b0;
    end
    exp_q.push_back(e);

    ex_valid = 1'b1; mem_rd = rd; mem_wr = wr; ALU_result = addr;
    Reg2_out = wdata; R_dest_exec = dest; reg_wr = rw;
    @(posedge clk); #1;
    if (memop && !addr_misaligned(addr)) begin
      for (int c = 1; c <= int'(TO); c++) begin
        check("stall_in_access", 32'(stall_out), 32'd1);
        check("dmem_req_in_access", 32'(dmem_req), 32'd1);
        check("dmem_we", 32'(dmem_we), 32'(store));
        check("dmem_addr", dmem_addr, addr);
        check("dmem_wdata", dmem_wdata, wdata);
        // Upstream keeps offering something; it must be ignored while stalled
        ex_valid = 1'b1; mem_rd = 1'($urandom); mem_wr = 1'($urandom);
        ALU_result = $urandom; Reg2_out = $urandom; R_dest_exec = 5'($urandom);
        reg_wr = 1'($urandom);
        dmem_ack   = (c == ack_lat);
        dmem_rdata = (c == ack_lat) ? rdata : $urandom;
        @(posedge clk); #1;
        if (c == cycles) break;
      end
      dmem_ack = 1'b0;
    end
    check("stall_after_retire", 32'(stall_out), 32'd0);
    check("dmem_req_after_retire", 32'(dmem_req), 32'd0);
    ex_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  // Idle cycles with stray acks that must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ex_valid = 1'b0;
      dmem_ack = 1'($urandom);
      dmem_rdata = $urandom;
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ALU_result = '0; Reg2_out = '0; R_dest_exec = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; reg_wr = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'({stall_out, dmem_req, dmem_we, wb_valid, wb_regwr, bus_err, align_err}), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    reset = 1'b0;
    idle(2);

    // Directed cases
    issue(1'b0, 1'b0, 32'h0000_0010, 32'h0, 5'd5, 1'b1, 0, 32'h0);            // ALU op
    issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 3, 32'hDEAD_BEEF);    // load, ack cycle 3
    issue(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 5'd9, 1'b1, 1, 32'h55);   // store
    issue(1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd3, 1'b1, 0, 32'h0);            // timeout
    issue(1'b1, 1'b0, 32'h0000_0304, 32'h0, 5'd4, 1'b1, int'(TO), 32'hCAFE);  // ack on timeout cycle
    issue(1'b1, 1'b1, 32'h0000_0308, 32'hABCD, 5'd6, 1'b1, 2, 32'h77);        // rd+wr = store
    issue(1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd8, 1'b1, 2, 32'h0BAD_F00D);    // unaligned load
    idle(2);

    // Reset during the second ACCESS cycle of a load
    ex_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; ALU_result = 32'h400; R_dest_exec = 5'd2; reg_wr = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_rd = 1'b0;
    check("pre_rst_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("async_rst_req", 32'(dmem_req), 32'd0);
    check("async_rst_stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(6);
    check("no_wb_after_rst", 32'(exp_q.size()), 32'd0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int kind, lsel, lat;
      kind = int'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      lsel = int'($urandom_range(0, 9));
      lat = (lsel == 0) ? 0 : (lsel == 1) ? int'(TO) : (lsel == 2) ? int'(TO) + 1
          : int'($urandom_range(1, 4));
      issue(kind == 1 || kind == 3, kind >= 2, a, $urandom, 5'($urandom), 1'($urandom),
            lat, $urandom);
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15: max ACCESS cycles without dmem_ack before abort; 0 disables timeout.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ex_valid  input  1  execute stage presents a valid instruction.
REQ-005 ALU_result  input  32  ALU output; memory address for loads/stores.
REQ-006 Reg2_out  input  32  store data.
REQ-007 R_dest_exec  input  5  destination register.
REQ-008 mem_rd / mem_wr / reg_wr  input  1 each  load, store, register-write controls.
REQ-009 stall_out  output  1  upstream holds its current instruction while high.
REQ-010 dmem_req, dmem_we  output  1 each  data-memory request, write enable.
REQ-011 dmem_addr, dmem_wdata  output  32 each  memory address, write data.
REQ-012 dmem_rdata  input  32; dmem_ack  input  1  read data, access-complete strobe.
REQ-013 wb_valid  output  1  one-cycle retire pulse toward writeback.
REQ-014 wb_data  output  32; wb_dest  output  5; wb_regwr  output  1  writeback payload.
REQ-015 bus_err, align_err  output  1 each  one-cycle error pulses.

Function
REQ-016 FSM states IDLE and ACCESS; stall_out = 1 exactly when state is ACCESS (decoded from state register only).
REQ-017 IDLE, ex_valid=1, mem_rd=mem_wr=0: next edge wb_valid=1, wb_data=ALU_result, wb_dest=R_dest_exec, wb_regwr=reg_wr; state stays IDLE (latency 1).
REQ-018 IDLE, ex_valid=1, mem_rd or mem_wr: next edge latch all inputs, enter ACCESS, clear timeout counter; no wb_valid that edge.
REQ-019 ACCESS: dmem_req=1, dmem_we=latched mem_wr, dmem_addr=latched ALU_result, dmem_wdata=latched Reg2_out, all held stable until exit.
REQ-020 ACCESS with dmem_ack=1: next edge return IDLE, wb_valid=1, wb_data = captured dmem_rdata for loads else latched ALU_result, wb_dest latched, wb_regwr = latched reg_wr AND NOT latched mem_wr.
REQ-021 ACCESS without ack: counter increments; when counter reaches ACK_TIMEOUT-1 without ack, next edge return IDLE, bus_err=1, wb_valid=1, wb_regwr=0.
REQ-022 mem_rd and mem_wr both high: treated as store.
REQ-023 dmem_ack in IDLE ignored; ack on the timeout cycle wins over timeout.
REQ-024 ex_valid ignored while ACCESS; an instruction held during stall is accepted in the first IDLE cycle (one cycle after the ack/timeout edge).
REQ-025 wb_valid, bus_err, align_err are single-cycle pulses; wb_data/wb_dest hold last value otherwise.
REQ-026 dmem_req low in IDLE; dmem_addr/dmem_wdata don't-care there but driven from latches (no X).

Reset
REQ-027 reset asserted: state IDLE, counter 0, all latches 0, every output 0 (stall_out, dmem_*, wb_*, bus_err, align_err), asynchronously.
REQ-028 reset during ACCESS: dmem_req drops without waiting for clk; pending access discarded, no wb_valid afterward.

Configuration
REQ-029 Macro MEM_ALIGN_CHECK_EN defined: IDLE memory op with ALU_result[1:0]!=0 does not enter ACCESS; next edge align_err=1, wb_valid=1, wb_regwr=0, no dmem_req.
REQ-030 MEM_ALIGN_CHECK_EN undefined: no alignment check, full address passed to dmem_addr, align_err tied 0.

Verification
REQ-031 ALU op: ALU_result=0x0000_0010, R_dest_exec=5, reg_wr=1 -> next cycle wb_valid=1, wb_data=0x10, wb_dest=5, stall_out never high.
REQ-032 Load addr 0x100, ack after 3 cycles with dmem_rdata=0xDEAD_BEEF -> dmem_req high 3 cycles, stall_out high 3 cycles, then wb_data=0xDEADBEEF, wb_regwr=1.
REQ-033 Store addr 0x200, Reg2_out=0x1234_5678, reg_wr=1, ack after 1 cycle -> dmem_we=1, dmem_wdata=0x12345678, wb_regwr=0.
REQ-034 Load, no ack, ACK_TIMEOUT=15 -> dmem_req high exactly 15 cycles, then bus_err pulse, wb_regwr=0, IDLE.
REQ-035 Reset asserted mid-ACCESS (cycle 2 of load) -> dmem_req and stall_out 0 immediately, no wb_valid after release.
REQ-036 MEM_ALIGN_CHECK_EN defined, load addr 0x102 -> align_err pulse, no dmem_req; undefined -> normal access to 0x102.
